// File: rtl/oob_retry_ctrl_if.sv
// Handshake between the link supervisor and the OOB sequencing engine.
// master = supervisor (drives start/allow/elecidle), slave = OOB engine.
interface oob_retry_ctrl_if;
   logic oob_start;
   logic cominit_allow;
   logic force_elecidle;
   logic oob_busy;
   logic oob_done;
   logic link_up;
   logic link_down;
   logic oob_error;
   logic oob_silence;
   logic cominit_req;

   modport master (
      output oob_start, cominit_allow, force_elecidle,
      input  oob_busy, oob_done, link_up, link_down, oob_error, oob_silence, cominit_req
   );

   modport slave (
      input  oob_start, cominit_allow, force_elecidle,
      output oob_busy, oob_done, link_up, link_down, oob_error, oob_silence, cominit_req
   );
endinterface

// File: rtl/oob_retry_ctrl.sv
// SATA link bring-up supervisor: bounded OOB retries with exponential
// backoff, device COMINIT handling, AHCI-style DET and link-drop statistics.
// All outputs are registered from the next-state decode.
module oob_retry_ctrl #(
   parameter int MAX_RETRIES       = 8,
   parameter int BACKOFF_LOG2      = 10,
   parameter int BACKOFF_SHIFT_MAX = 4,
   parameter bit AUTO_START        = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  gtx_ready,
   input  logic                  rxbyteisaligned,
   input  logic                  set_offline,
   input  logic                  comreset_send,
   oob_retry_ctrl_if.master      eng,
   output logic                  phy_ready,
   output logic [3:0]            det,
   output logic [3:0]            retry_cnt,
   output logic [7:0]            link_drops,
   output logic                  oob_failed
);

   localparam int TW = BACKOFF_LOG2 + BACKOFF_SHIFT_MAX + 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_LINK    = 3'd3;
   localparam logic [2:0] S_BACKOFF = 3'd4;
   localparam logic [2:0] S_FAILED  = 3'd5;
   localparam logic [2:0] S_OFFLINE = 3'd6;

   logic [2:0]    state, nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [3:0]    retry_nxt;
   logic [7:0]    drops_nxt;
   logic          start_nxt, allow_nxt, phy_nxt;
   logic [3:0]    det_nxt;

   // Engine completion is implied by link_up; the strobe is carried for
   // interface completeness only.
   logic unused_done;
   assign unused_done = eng.oob_done;

   // Backoff reload value: 2^(BACKOFF_LOG2 + min(k, cap)) - 1.
   function automatic logic [TW-1:0] backoff_load(input logic [3:0] k);
      int unsigned   e;
      logic [TW-1:0] one;
      one = 1;
      e   = BACKOFF_LOG2 + ((int'(k) > BACKOFF_SHIFT_MAX) ? BACKOFF_SHIFT_MAX : int'(k));
      return (one << e) - one;
   endfunction

   // Saturating increment for the link-drop statistic.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Next-state, counter and output decode with event priority
   // comreset_send > set_offline > cominit_req > engine events.
   always_comb begin
      nxt       = state;
      timer_nxt = timer;
      retry_nxt = retry_cnt;
      drops_nxt = link_drops;
      start_nxt = 1'b0;
      allow_nxt = 1'b0;
      if (comreset_send) begin
         nxt       = S_START;
         retry_nxt = 4'd0;
      end else if (set_offline) begin
         nxt = S_OFFLINE;
      end else if (eng.cominit_req &&
                   (state == S_IDLE || state == S_LINK ||
                    state == S_BACKOFF || state == S_FAILED)) begin
         allow_nxt = 1'b1;
         nxt       = S_WAIT;
         if (state == S_FAILED) retry_nxt = 4'd0;
      end else begin
         case (state)
            S_IDLE:
               if (AUTO_START && gtx_ready) nxt = S_START;
            S_START:
               if (gtx_ready && !eng.oob_busy) begin
                  start_nxt = 1'b1;
                  nxt       = S_WAIT;
               end
            S_WAIT:
               // A successful link_up outranks a simultaneous failure report.
               if (eng.link_up) begin
                  nxt       = S_LINK;
                  retry_nxt = 4'd0;
               end else if (eng.oob_error || eng.oob_silence) begin
                  if (retry_cnt == 4'(MAX_RETRIES - 1)) begin
                     nxt       = S_FAILED;
                     retry_nxt = 4'(MAX_RETRIES);
                  end else begin
                     retry_nxt = retry_cnt + 4'd1;
                     timer_nxt = backoff_load(retry_cnt + 4'd1);
                     nxt       = S_BACKOFF;
                  end
               end
            S_LINK:
               if (eng.link_down) begin
                  drops_nxt = sat_inc8(link_drops);
                  retry_nxt = 4'd0;
                  timer_nxt = backoff_load(4'd0);
                  nxt       = S_BACKOFF;
               end
            S_BACKOFF:
               if (timer == '0) nxt = S_START;
               else             timer_nxt = timer - 1'b1;
            default: ;
         endcase
      end

      phy_nxt = (nxt == S_LINK) && gtx_ready && rxbyteisaligned;
      if (nxt == S_OFFLINE)                                       det_nxt = 4'd4;
      else if (phy_nxt)                                           det_nxt = 4'd3;
      else if (nxt == S_WAIT || nxt == S_BACKOFF || nxt == S_LINK) det_nxt = 4'd1;
      else                                                        det_nxt = 4'd0;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= S_IDLE;
         timer              <= '0;
         retry_cnt          <= 4'd0;
         link_drops         <= 8'd0;
         eng.oob_start      <= 1'b0;
         eng.cominit_allow  <= 1'b0;
         eng.force_elecidle <= 1'b0;
         phy_ready          <= 1'b0;
         det                <= 4'd0;
         oob_failed         <= 1'b0;
      end else begin
         state              <= nxt;
         timer              <= timer_nxt;
         retry_cnt          <= retry_nxt;
         link_drops         <= drops_nxt;
         eng.oob_start      <= start_nxt;
         eng.cominit_allow  <= allow_nxt;
         eng.force_elecidle <= (nxt == S_OFFLINE);
         phy_ready          <= phy_nxt;
         det                <= det_nxt;
         oob_failed         <= (nxt == S_FAILED);
      end
   end

endmodule

// File: tb/tb_oob_retry_ctrl.sv
// Directed bench for oob_retry_ctrl with MAX_RETRIES=3, BACKOFF_LOG2=4,
// BACKOFF_SHIFT_MAX=1, AUTO_START=1. Gaps are counted in clock edges from
// the edge that samples the causing event to the edge that raises oob_start:
// backoff of 2^n cycles + 1 event edge + 1 START edge.
module tb_oob_retry_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       gtx_ready, rxbyteisaligned, set_offline, comreset_send;
   logic       phy_ready, oob_failed;
   logic [3:0] det, retry_cnt;
   logic [7:0] link_drops;

   int checks = 0;
   int errors = 0;
   int n, pulses;

   oob_retry_ctrl_if bus();

   oob_retry_ctrl #(
      .MAX_RETRIES(3), .BACKOFF_LOG2(4), .BACKOFF_SHIFT_MAX(1), .AUTO_START(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .gtx_ready(gtx_ready), .rxbyteisaligned(rxbyteisaligned),
      .set_offline(set_offline), .comreset_send(comreset_send), .eng(bus),
      .phy_ready(phy_ready), .det(det), .retry_cnt(retry_cnt),
      .link_drops(link_drops), .oob_failed(oob_failed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Edges until oob_start is seen; -1 if the budget expires.
   task automatic wait_start(input int budget, output int cnt);
      cnt = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (bus.oob_start) begin
            cnt = i;
            break;
         end
      end
   endtask

   task automatic silence_once();
      bus.oob_silence = 1'b1;
      step();
      bus.oob_silence = 1'b0;
   endtask

   initial begin
      rst = 1'b1; gtx_ready = 1'b1; rxbyteisaligned = 1'b0;
      set_offline = 1'b0; comreset_send = 1'b0;
      bus.oob_busy = 1'b0; bus.oob_done = 1'b0; bus.link_up = 1'b0;
      bus.link_down = 1'b0; bus.oob_error = 1'b0; bus.oob_silence = 1'b0;
      bus.cominit_req = 1'b0;
      repeat (3) step();
      chk("rst_start", bus.oob_start, 0);
      chk("rst_allow", bus.cominit_allow, 0);
      chk("rst_elecidle", bus.force_elecidle, 0);
      chk("rst_phy", phy_ready, 0);
      chk("rst_det", det, 0);
      chk("rst_retry", retry_cnt, 0);
      chk("rst_drops", link_drops, 0);
      chk("rst_failed", oob_failed, 0);

      // Auto start: IDLE -> START -> WAIT with pulse
      rst = 1'b0;
      wait_start(10, n);
      chk("first_start", n, 2);
      step();
      chk("start_one_cycle", bus.oob_start, 0);

      // Engine answers link_up 20 cycles after oob_start
      pulses = 0;
      for (int i = 0; i < 18; i++) begin
         step();
         pulses += int'(bus.oob_start);
      end
      bus.link_up = 1'b1;
      step();
      bus.link_up = 1'b0;
      pulses += int'(bus.oob_start);
      chk("extra_starts", pulses, 0);
      chk("link_unaligned_phy", phy_ready, 0);
      chk("link_unaligned_det", det, 1);
      rxbyteisaligned = 1'b1;
      step();
      chk("link_phy", phy_ready, 1);
      chk("link_det", det, 3);
      chk("link_retry", retry_cnt, 0);

      // 300 link drops: 16-cycle backoff each, counter saturates
      for (int i = 0; i < 300; i++) begin
         bus.link_down = 1'b1;
         step();
         bus.link_down = 1'b0;
         if (i == 0) begin
            chk("drop_phy", phy_ready, 0);
            chk("drop_det", det, 1);
         end
         wait_start(40, n);
         chk("drop_gap", (n < 0) ? n : n + 1, 18);
         bus.link_up = 1'b1;
         step();
         bus.link_up = 1'b0;
      end
      chk("drops_sat", link_drops, 255);
      chk("drops_retry", retry_cnt, 0);

      // comreset from LINK, then silence to every attempt
      comreset_send = 1'b1;
      step();
      comreset_send = 1'b0;
      wait_start(10, n);
      chk("creset_lat", n, 1);
      silence_once();
      chk("sil1_retry", retry_cnt, 1);
      wait_start(60, n);
      chk("sil1_gap", (n < 0) ? n : n + 1, 34);
      silence_once();
      chk("sil2_retry", retry_cnt, 2);
      wait_start(60, n);
      chk("sil2_gap", (n < 0) ? n : n + 1, 34);
      silence_once();
      chk("failed_flag", oob_failed, 1);
      chk("failed_retry", retry_cnt, 3);
      chk("failed_det", det, 0);
      wait_start(100, n);
      chk("failed_no_start", n, -1);

      // cominit in FAILED
      bus.cominit_req = 1'b1;
      step();
      bus.cominit_req = 1'b0;
      chk("cominit_allow", bus.cominit_allow, 1);
      chk("cominit_det", det, 1);
      chk("cominit_retry", retry_cnt, 0);
      chk("cominit_unfail", oob_failed, 0);
      step();
      chk("cominit_one_cycle", bus.cominit_allow, 0);

      // Back to FAILED, then comreset out of it
      silence_once();
      wait_start(60, n);
      silence_once();
      wait_start(60, n);
      silence_once();
      chk("failed2_flag", oob_failed, 1);
      comreset_send = 1'b1;
      step();
      comreset_send = 1'b0;
      chk("creset_retry", retry_cnt, 0);
      chk("creset_unfail", oob_failed, 0);
      wait_start(10, n);
      chk("creset_fail_lat", n, 1);

      // set_offline with comreset_send: START wins
      set_offline = 1'b1; comreset_send = 1'b1;
      step();
      set_offline = 1'b0; comreset_send = 1'b0;
      chk("both_elecidle", bus.force_elecidle, 0);
      wait_start(10, n);
      chk("both_start", n, 1);
      bus.link_up = 1'b1;
      step();
      bus.link_up = 1'b0;
      chk("pre_off_phy", phy_ready, 1);
      set_offline = 1'b1;
      step();
      set_offline = 1'b0;
      chk("off_elecidle", bus.force_elecidle, 1);
      chk("off_det", det, 4);
      chk("off_phy", phy_ready, 0);
      bus.cominit_req = 1'b1;
      step();
      bus.cominit_req = 1'b0;
      chk("off_cominit_ignored", bus.cominit_allow, 0);
      wait_start(100, n);
      chk("off_no_start", n, -1);
      comreset_send = 1'b1;
      step();
      comreset_send = 1'b0;
      chk("off_exit_elecidle", bus.force_elecidle, 0);
      wait_start(10, n);
      chk("off_exit_start", n, 1);

      // oob_busy held 10 cycles on entering START
      bus.oob_busy = 1'b1; comreset_send = 1'b1;
      step();
      comreset_send = 1'b0;
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         pulses += int'(bus.oob_start);
      end
      chk("busy_no_start", pulses, 0);
      bus.oob_busy = 1'b0;
      wait_start(10, n);
      chk("busy_release", n, 1);

      // oob_error then link_up+oob_error together -> LINK
      bus.oob_error = 1'b1;
      step();
      bus.oob_error = 1'b0;
      chk("err_retry", retry_cnt, 1);
      wait_start(60, n);
      chk("err_gap", (n < 0) ? n : n + 1, 34);
      bus.link_up = 1'b1; bus.oob_error = 1'b1;
      step();
      bus.link_up = 1'b0; bus.oob_error = 1'b0;
      chk("race_det", det, 3);
      chk("race_phy", phy_ready, 1);
      chk("race_retry", retry_cnt, 0);

      // comreset during BACKOFF abandons the timer
      bus.link_down = 1'b1;
      step();
      bus.link_down = 1'b0;
      repeat (3) step();
      comreset_send = 1'b1;
      step();
      comreset_send = 1'b0;
      wait_start(10, n);
      chk("backoff_abort", n, 1);

      // rst mid-operation clears statistics
      rst = 1'b1;
      step();
      chk("rst_mid_drops", link_drops, 0);
      chk("rst_mid_det", det, 0);
      chk("rst_mid_phy", phy_ready, 0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
